load_align_unit: RTL
====================

# load_align_unit

Parametrised, handshaked successor to the combinational load-size extractor. Takes a load request (size, signedness, byte offset), captures one or two memory read beats, then aligns, truncates and zero- or sign-extends the addressed field. Holds the result until the register write-back stage accepts it. Sits between the memory data register and the MemToReg mux; it also handles loads that straddle a word boundary by requesting a second sequential beat.

## Interface
- DATA_W, 32: memory beat and result width; legal values are 32 or 64.
- OFF_W, $clog2(DATA_W/8): derived width of the byte offset; do not override.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset; one clock; sampled on the rising edge of clk.
- req_valid  in  1  load request present.
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready.
- req_size  in  2  01 word (32b), 10 halfword, 11 byte, 00 doubleword (DATA_W=64 only; illegal at 32).
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- req_offset  in  OFF_W  byte offset of the field within the first beat.
- mem_rd_valid  in  1  mem_rd_data valid this cycle.
- mem_rd_data  in  DATA_W  memory read beat.
- mem_next  out  1  single-cycle pulse requesting the next sequential beat.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  write-back accepts the result.
- rsp_data  out  DATA_W  aligned, extended result.
- rsp_misaligned  out  1  result assembled from two beats.
- rsp_err  out  1  illegal size; rsp_data forced to 0.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP. req_ready = (state == IDLE).
- IDLE: on accept, latch size, signed and offset, and compute nbytes (1/2/4/8). Go to BEAT0. If the size is illegal, go directly to RESP with err=1.
- BEAT0: on mem_rd_valid, capture the beat into lo.
  - If offset + nbytes <= DATA_W/8, go to RESP.
  - Otherwise go to BEAT1.
- BEAT1: mem_next = 1 in the first BEAT1 cycle only. Capture the next mem_rd_valid beat (including one in the same cycle as mem_next) into hi, then go to RESP with misaligned=1.
- Extraction: shifted = {hi, lo} >> (8*offset). Take the low 8*nbytes bits. Fill the upper bits with the field MSB if signed, else 0. For an aligned load, hi is treated as 0.
- Word at DATA_W=64: the field is 32 bits, extended to 64 bits.
- RESP: rsp_valid = 1. rsp_data, rsp_misaligned and rsp_err stay stable until rsp_ready. On handshake, go to IDLE.
- mem_rd_valid is ignored in IDLE and RESP. req_valid is ignored outside IDLE.
- Reset (any state, including mid-BEAT1): state goes to IDLE. A pending transaction is dropped and no response is produced.

## Timing
- Reset values: req_ready=1 (IDLE), mem_next=0, rsp_valid=0, rsp_data=0, rsp_misaligned=0, rsp_err=0.
- Accept at cycle t: BEAT0 from t+1. The earliest beat is accepted at t+1.
- Aligned load, beat at cycle b: rsp_valid rises at b+1.
- Misaligned load, beat0 at b: mem_next is high at b+1. The second beat is accepted at b+1 or later (cycle c), and rsp_valid rises at c+1.
- Illegal size accepted at t: rsp_valid at t+1, err=1, no mem_next.
- Response handshake at cycle r: req_ready is high at r+1. There are no back-to-back accepts within the same cycle.
- All outputs are registered or pure state decode. There is no combinational path from rsp_ready or mem_rd_valid to any output.

## Test plan
- DATA_W=32, byte signed, offset 3, beat 0x80FF_1234 at cycle b -> rsp_data 0xFFFF_FF80 at b+1, misaligned=0, no mem_next.
- Half unsigned, offset 1, beat 0xABCD_EF01 -> rsp_data 0x0000_CDEF, single beat.
- Word offset 2, beat0 0x4433_2211, beat1 0x8877_6655 delayed 2 cycles after mem_next -> exactly one mem_next pulse, rsp_data 0x6655_4433, rsp_misaligned=1.
- DATA_W=32, req_size 00 -> rsp_err=1, rsp_data 0 one cycle after accept, no mem_next; stray mem_rd_valid ignored.
- DATA_W=64, doubleword offset 0, beat 0x8000_0000_0000_0001 -> rsp_data equal to the beat.
  - Then half signed, offset 7, beat0 top byte 0x34, beat1 low byte 0x92 -> 0xFFFF_FFFF_FFFF_9234.
- Backpressure: rsp_ready held low for 3 cycles -> rsp_data stable, req_ready=0, req_valid ignored.
  - Then reset_n low during BEAT1 -> IDLE next cycle, all outputs at reset values, late beat produces no response.

Source files
------------

// File: rtl/load_align_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_align_unit_if
//  Purpose  : Request / memory-beat / response bundle for load_align_unit.
//             "master" is the requester side (pipeline + memory), "slave" is
//             the alignment unit itself.
//  Revision : 1.0  initial release
// ============================================================================
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [OFF_W-1:0]  req_offset;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              mem_next;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_misaligned;
  logic              rsp_err;

  modport master (
    output req_valid, req_size, req_signed, req_offset,
    output mem_rd_valid, mem_rd_data, rsp_ready,
    input  req_ready, mem_next, rsp_valid, rsp_data, rsp_misaligned, rsp_err
  );

  modport slave (
    input  req_valid, req_size, req_signed, req_offset,
    input  mem_rd_valid, mem_rd_data, rsp_ready,
    output req_ready, mem_next, rsp_valid, rsp_data, rsp_misaligned, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_align_unit
//  Purpose  : Handshaked load extractor. Captures one or two read beats,
//             shifts the addressed field down, truncates it and zero/sign
//             extends it, then holds the result until write-back accepts it.
//  Revision : 1.0  initial release
// ============================================================================
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic               clk,
  input  logic               reset_n,
  load_align_unit_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BEAT0 = 2'd1;
  localparam logic [1:0] ST_BEAT1 = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int BEAT_BYTES = DATA_W / 8;

  logic [1:0]        state_q, state_d;
  logic [OFF_W-1:0]  offset_q;
  logic [3:0]        nbytes_q;
  logic              signed_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              mis_q;
  logic              err_q;
  logic              mem_next_q;

  logic [3:0]          w_nbytes;
  logic                w_illegal;
  logic                w_accept;
  logic                w_beat0;
  logic                w_beat1;
  logic [4:0]          w_span;
  logic                w_straddle;
  logic [DATA_W-1:0]   w_lo;
  logic [DATA_W-1:0]   w_hi;
  logic [2*DATA_W-1:0] w_shifted;
  logic [6:0]          w_fbits;
  logic [DATA_W-1:0]   w_mask;
  logic [DATA_W-1:0]   w_top;
  logic [DATA_W-1:0]   w_field;
  logic                w_fill;
  logic [DATA_W-1:0]   w_result;

  // Decode the requested size into a byte count; doubleword only exists at 64b.
  always_comb begin
    w_nbytes = 4'd8;
    case (bus.req_size)
      2'b11:   w_nbytes = 4'd1;
      2'b10:   w_nbytes = 4'd2;
      2'b01:   w_nbytes = 4'd4;
      default: w_nbytes = 4'd8;
    endcase
  end

  assign w_illegal  = (bus.req_size == 2'b00) && (DATA_W != 64);
  assign w_accept   = bus.req_valid && (state_q == ST_IDLE);
  assign w_beat0    = bus.mem_rd_valid && (state_q == ST_BEAT0);
  assign w_beat1    = bus.mem_rd_valid && (state_q == ST_BEAT1);
  assign w_span     = 5'(offset_q) + 5'(nbytes_q);
  assign w_straddle = w_span > 5'(BEAT_BYTES);

  // Extraction works on the beat arriving this cycle: in BEAT0 it is the low
  // half (upper half zero), in BEAT1 it is the high half above the held beat.
  assign w_lo      = (state_q == ST_BEAT1) ? lo_q : bus.mem_rd_data;
  assign w_hi      = (state_q == ST_BEAT1) ? bus.mem_rd_data : '0;
  assign w_shifted = {w_hi, w_lo} >> {offset_q, 3'b000};
  assign w_fbits   = {nbytes_q, 3'b000};
  assign w_mask    = {DATA_W{1'b1}} >> (7'(DATA_W) - w_fbits);
  assign w_top     = w_mask & ~(w_mask >> 1);
  assign w_field   = w_shifted[DATA_W-1:0] & w_mask;
  assign w_fill    = signed_q && (|(w_field & w_top));
  assign w_result  = w_field | (w_fill ? ~w_mask : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.req_valid)    state_d = w_illegal ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (bus.mem_rd_valid) state_d = w_straddle ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (bus.mem_rd_valid) state_d = ST_RESP;
      ST_RESP:  if (bus.rsp_ready)    state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Outputs: pure state decode or straight from registers.
  always_comb begin
    bus.req_ready      = (state_q == ST_IDLE);
    bus.rsp_valid      = (state_q == ST_RESP);
    bus.mem_next       = mem_next_q;
    bus.rsp_data       = rsp_data_q;
    bus.rsp_misaligned = mis_q;
    bus.rsp_err        = err_q;
  end

  // Request latch, beat capture and result register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      offset_q   <= '0;
      nbytes_q   <= 4'd0;
      signed_q   <= 1'b0;
      lo_q       <= '0;
      rsp_data_q <= '0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
      mem_next_q <= 1'b0;
    end else begin
      // High only in the first BEAT1 cycle.
      mem_next_q <= w_beat0 && w_straddle;
      if (w_accept) begin
        offset_q <= bus.req_offset;
        nbytes_q <= w_nbytes;
        signed_q <= bus.req_signed;
        mis_q    <= 1'b0;
        err_q    <= w_illegal;
        if (w_illegal) rsp_data_q <= '0;
      end
      if (w_beat0) lo_q <= bus.mem_rd_data;
      if ((w_beat0 && !w_straddle) || w_beat1) begin
        rsp_data_q <= w_result;
        mis_q      <= w_beat1;
      end
    end
  end

endmodule
`default_nettype wire
